trigger_sequencer: RTL and testbench
====================================

// Module: trigger_sequencer
// PURPOSE
//  Multi-stage trigger sequencer between the pattern matchers and the trigger/capture block.
//  Sequences up to pSTAGES match events, each from a selectable matcher, with an optional
//  timing window between consecutive stages.
//  Issues a single-cycle O_match pulse when the full sequence completes; O_match drives
//  the trigger block's match input.
//  Configuration is latched on arm, so firmware can reprogram it safely while a sequence runs.
// PARAMETERS
//  pSEL_WIDTH    2   matcher index width; number of matchers pNUM_MATCH = 2**pSEL_WIDTH
//  pSTAGES       4   max sequence stages (power of 2); stage index width pSTG_W = clog2(pSTAGES)
//  pWIN_WIDTH    16  per-stage window counter width
//  pCOUNT_WIDTH  16  timeout counter width
// PORTS
//  fe_clk          in   1                       front-end clock; all logic in this domain
//  reset_i         in   1                       asynchronous active-high reset
//  I_arm           in   1                       arm level; rising edge starts/restarts sequence
//  I_abort         in   1                       synchronous abort to IDLE
//  I_num_stages    in   pSTG_W                  number of stages minus 1
//  I_rearm         in   1                       1: after completion restart at stage 0 (stay RUN)
//  I_stage_sel     in   pSTAGES*pSEL_WIDTH      matcher index for stage k at [k*pSEL_WIDTH +: pSEL_WIDTH]
//  I_stage_window  in   pSTAGES*pWIN_WIDTH      window for stage k>=1; 0 = unlimited; stage 0 field unused
//  I_match_vec     in   pNUM_MATCH              per-matcher match strobes
//  O_match         out  1                       sequence-complete pulse (registered)
//  O_state         out  2                       0 IDLE, 1 RUN, 2 DONE
//  O_stage         out  pSTG_W                  current stage index
//  O_timeouts      out  pCOUNT_WIDTH            window-expiry count, saturating
// BEHAVIOUR
//  Reset: O_match=0, O_state=IDLE, O_stage=0, O_timeouts=0, arm_r=0, window count=0, shadow config=0.
//  Reset is asynchronous; mid-operation it forces all of these values immediately.
//  Arm edge: I_arm & ~arm_r, where arm_r is I_arm registered.
//  Priority: reset > I_abort > arm edge > sequencing.
//  Abort: O_state<=IDLE, O_stage<=0, window count cleared. O_timeouts is held.
//  Arm edge (from any state):
//   - latches I_num_stages, I_rearm, I_stage_sel and I_stage_window into shadow registers
//   - O_state<=RUN, O_stage<=0, O_timeouts<=0, window count cleared
//   - I_match_vec is not evaluated in the arm-edge cycle
//  IDLE and DONE: I_match_vec is ignored.
//  RUN: hit = I_match_vec[sel_sh[O_stage]].
//   - hit and O_stage < num_sh: O_stage+1 on the next cycle; window count reset to 0.
//   - hit and O_stage == num_sh: O_match=1 on the next cycle (1-cycle latency from I_match_vec).
//     Then O_stage<=0. O_state<=RUN if rearm_sh, else O_state<=DONE.
//   - no hit: no stage change.
//  Window for stage k>=1 with shadow window W != 0:
//   - stage k entered at cycle t (its first cycle in O_stage).
//   - hit accepted on cycles t..t+W-1, i.e. W evaluation cycles.
//   - no hit by t+W-1: O_stage<=0 at t+W; O_timeouts+1, saturating at all-ones.
//   - hit on the final window cycle is accepted; a hit there wins over the timeout.
//   - match strobes in the timeout cycle are not re-evaluated against stage 0.
//  Window W==0: stage waits indefinitely. Stage 0 never times out. Window count is pWIN_WIDTH bits.
//  Repeated stage: a hit advances only one stage per cycle, even if the next stage selects the same matcher.
//  O_match is 0 in every cycle except the single completion pulse.
//  Back-to-back completions with rearm_sh: one pulse per completing hit.
// TESTING
//  1 Sequence: num=1, sel0=0, sel1=2, win1=5; arm, match_vec[0] @t, [2] @t+3
//    -> O_stage=1 @t+1, O_match pulse @t+4, O_state=DONE @t+4.
//  2 Window edge: as test 1, [0] @t. [2] @t+5 -> accepted, O_match @t+6.
//    Repeat with [2] @t+6 -> no O_match, O_stage=0 @t+6, O_timeouts=1.
//  3 Rearm: num=0, sel0=1, rearm=1; [1] pulsed 3 times -> 3 O_match pulses, O_state stays RUN.
//    Then re-arm -> O_timeouts cleared, O_stage=0.
//  4 Shadow/abort: change I_stage_sel mid-RUN -> old sequence still used.
//    Abort while O_stage=2 -> IDLE, matches ignored.
//    Arm edge + abort same cycle -> IDLE.
//  5 Async reset asserted mid-RUN between clock edges -> all outputs at reset values immediately.
//    Saturation: force 2**pCOUNT_WIDTH+1 timeouts -> O_timeouts=all-ones.
//  6 Unlimited window: win1=0, [2] arrives 1000 cycles after [0] -> O_match.
//    Stage 0 never times out.

Source files
------------

// File: rtl/trigger_sequencer_if.sv
// Bundle between firmware/config logic and the trigger sequencer:
// arm/abort control, shadowed sequence configuration, matcher strobes
// and the sequencer status/pulse outputs.
interface trigger_sequencer_if #(
    parameter int pSEL_WIDTH   = 2,
    parameter int pSTAGES      = 4,
    parameter int pWIN_WIDTH   = 16,
    parameter int pCOUNT_WIDTH = 16
);
    localparam int pNUM_MATCH = 2 ** pSEL_WIDTH;
    localparam int pSTG_W     = $clog2(pSTAGES);

    logic                             I_arm;
    logic                             I_abort;
    logic [pSTG_W-1:0]                I_num_stages;
    logic                             I_rearm;
    logic [pSTAGES*pSEL_WIDTH-1:0]    I_stage_sel;
    logic [pSTAGES*pWIN_WIDTH-1:0]    I_stage_window;
    logic [pNUM_MATCH-1:0]            I_match_vec;
    logic                             O_match;
    logic [1:0]                       O_state;
    logic [pSTG_W-1:0]                O_stage;
    logic [pCOUNT_WIDTH-1:0]          O_timeouts;

    // Side that programs the sequencer and consumes its status.
    modport master (
        output I_arm, I_abort, I_num_stages, I_rearm, I_stage_sel,
               I_stage_window, I_match_vec,
        input  O_match, O_state, O_stage, O_timeouts
    );

    // The sequencer itself.
    modport slave (
        input  I_arm, I_abort, I_num_stages, I_rearm, I_stage_sel,
               I_stage_window, I_match_vec,
        output O_match, O_state, O_stage, O_timeouts
    );
endinterface

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger sequencer. Walks through up to pSTAGES matcher
// events (each stage picks one matcher), with an optional timing window
// per stage, and emits a single-cycle O_match pulse when the programmed
// sequence completes. Configuration is captured on the arm edge so it
// may be rewritten freely while a sequence is running.
module trigger_sequencer #(
    parameter int pSEL_WIDTH   = 2,
    parameter int pSTAGES      = 4,
    parameter int pWIN_WIDTH   = 16,
    parameter int pCOUNT_WIDTH = 16
) (
    input logic                fe_clk,
    input logic                reset_i,
    trigger_sequencer_if.slave bus
);
    localparam int pSTG_W = $clog2(pSTAGES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [pSTG_W-1:0]             stage_q, stage_d;
    logic [pWIN_WIDTH-1:0]         win_q, win_d;
    logic [pCOUNT_WIDTH-1:0]       tmo_q, tmo_d;
    logic                          match_q, match_d;
    logic                          arm_r;

    logic [pSTG_W-1:0]             num_sh;
    logic                          rearm_sh;
    logic [pSTAGES*pSEL_WIDTH-1:0] sel_sh;
    logic [pSTAGES*pWIN_WIDTH-1:0] win_sh;

    logic                          arm_edge;
    logic [pSEL_WIDTH-1:0]         sel_cur;
    logic [pWIN_WIDTH-1:0]         win_cur;
    logic                          hit;

    // Timeout counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [pCOUNT_WIDTH-1:0] sat_inc(input logic [pCOUNT_WIDTH-1:0] v);
        if (v == {pCOUNT_WIDTH{1'b1}})
            return v;
        return v + pCOUNT_WIDTH'(1);
    endfunction

    assign arm_edge = bus.I_arm & ~arm_r;
    assign sel_cur  = sel_sh[int'(stage_q)*pSEL_WIDTH +: pSEL_WIDTH];
    assign win_cur  = win_sh[int'(stage_q)*pWIN_WIDTH +: pWIN_WIDTH];
    assign hit      = bus.I_match_vec[sel_cur];

    // Registered copy of the arm level for rising-edge detection.
    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i)
            arm_r <= 1'b0;
        else
            arm_r <= bus.I_arm;
    end

    // Shadow configuration, captured only on an arm edge that abort does not override.
    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            num_sh   <= '0;
            rearm_sh <= 1'b0;
            sel_sh   <= '0;
            win_sh   <= '0;
        end else if (arm_edge && !bus.I_abort) begin
            num_sh   <= bus.I_num_stages;
            rearm_sh <= bus.I_rearm;
            sel_sh   <= bus.I_stage_sel;
            win_sh   <= bus.I_stage_window;
        end
    end

    // Sequencer state, stage, window and timeout registers.
    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            win_q   <= '0;
            tmo_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            win_q   <= win_d;
            tmo_q   <= tmo_d;
            match_q <= match_d;
        end
    end

    // Next-state: abort beats arm, arm beats sequencing; matches only count in RUN.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        win_d   = win_q;
        tmo_d   = tmo_q;
        match_d = 1'b0;
        if (bus.I_abort) begin
            state_d = ST_IDLE;
            stage_d = '0;
            win_d   = '0;
        end else if (arm_edge) begin
            state_d = ST_RUN;
            stage_d = '0;
            win_d   = '0;
            tmo_d   = '0;
        end else if (state_q == ST_RUN) begin
            if (hit) begin
                // A hit on the last window cycle still wins over the timeout.
                win_d = '0;
                if (stage_q == num_sh) begin
                    match_d = 1'b1;
                    stage_d = '0;
                    state_d = rearm_sh ? ST_RUN : ST_DONE;
                end else begin
                    stage_d = stage_q + pSTG_W'(1);
                end
            end else if (stage_q != '0 && win_cur != '0) begin
                // Window counts evaluation cycles spent in this stage; W cycles allowed.
                if (win_q == win_cur - pWIN_WIDTH'(1)) begin
                    stage_d = '0;
                    win_d   = '0;
                    tmo_d   = sat_inc(tmo_q);
                end else begin
                    win_d = win_q + pWIN_WIDTH'(1);
                end
            end
        end
    end

    assign bus.O_match    = match_q;
    assign bus.O_state    = state_q;
    assign bus.O_stage    = stage_q;
    assign bus.O_timeouts = tmo_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer. Stimulus pushes expected status
// snapshots (keyed by cycle) and expected O_match pulse cycles into
// queues; a separate monitor compares them against the DUT outputs.
// A second instance with a 4-bit timeout counter exercises saturation.
module tb_trigger_sequencer;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct {
        int         cyc;
        int         dut;
        logic [1:0] st;
        logic [1:0] stg;
        logic [15:0] tmo;
        string      name;
    } snap_t;

    logic fe_clk = 1'b0;
    logic reset_i;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   stim_done = 1'b0;

    snap_t snap_q[$];
    int    pulse_q[$];

    trigger_sequencer_if #(.pSEL_WIDTH(2), .pSTAGES(4), .pWIN_WIDTH(16), .pCOUNT_WIDTH(16)) bus ();
    trigger_sequencer_if #(.pSEL_WIDTH(2), .pSTAGES(4), .pWIN_WIDTH(16), .pCOUNT_WIDTH(4))  bus2 ();

    trigger_sequencer #(.pSEL_WIDTH(2), .pSTAGES(4), .pWIN_WIDTH(16), .pCOUNT_WIDTH(16)) dut (
        .fe_clk  (fe_clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    trigger_sequencer #(.pSEL_WIDTH(2), .pSTAGES(4), .pWIN_WIDTH(16), .pCOUNT_WIDTH(4)) dut_sat (
        .fe_clk  (fe_clk),
        .reset_i (reset_i),
        .bus     (bus2)
    );

    always #5 fe_clk = ~fe_clk;

    always @(posedge fe_clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge fe_clk);
    endtask

    task automatic snap(input int c, input int d, input logic [1:0] st, input int stg,
                        input int tmo, input string nm);
        snap_t s;
        s.cyc = c; s.dut = d; s.st = st; s.stg = 2'(stg); s.tmo = 16'(tmo); s.name = nm;
        snap_q.push_back(s);
    endtask

    task automatic pulse_at(input int c);
        pulse_q.push_back(c);
    endtask

    task automatic arm(input int num, input bit rearm, input logic [7:0] sel, input logic [63:0] win);
        bus.I_num_stages   = 2'(num);
        bus.I_rearm        = rearm;
        bus.I_stage_sel    = sel;
        bus.I_stage_window = win;
        bus.I_arm          = 1'b1;
        step(1);
        bus.I_arm          = 1'b0;
    endtask

    // Stimulus
    initial begin : stim
        int t;
        reset_i = 1'b1;
        bus.I_arm = 0; bus.I_abort = 0; bus.I_num_stages = 0; bus.I_rearm = 0;
        bus.I_stage_sel = 0; bus.I_stage_window = 0; bus.I_match_vec = 0;
        bus2.I_arm = 0; bus2.I_abort = 0; bus2.I_num_stages = 0; bus2.I_rearm = 0;
        bus2.I_stage_sel = 0; bus2.I_stage_window = 0; bus2.I_match_vec = 0;
        step(3);
        snap(cyc + 1, 0, S_IDLE, 0, 0, "reset_dut");
        snap(cyc + 1, 1, S_IDLE, 0, 0, "reset_dut_sat");
        step(1);
        reset_i = 1'b0;
        snap(cyc + 1, 0, S_IDLE, 0, 0, "reset_release");
        step(2);

        // Basic two-stage sequence
        t = cyc; snap(t + 1, 0, S_RUN, 0, 0, "t1_arm");
        arm(1, 0, {2'd0, 2'd0, 2'd2, 2'd0}, {16'd0, 16'd0, 16'd5, 16'd0});
        t = cyc; bus.I_match_vec = 4'b0001;
        snap(t + 1, 0, S_RUN, 1, 0, "t1_stage1");
        snap(t + 2, 0, S_RUN, 1, 0, "t1_wait");
        pulse_at(t + 4);
        snap(t + 4, 0, S_DONE, 0, 0, "t1_done");
        step(1); bus.I_match_vec = 4'b0000; step(2);
        bus.I_match_vec = 4'b0100; step(1);
        bus.I_match_vec = 4'b0001;
        snap(t + 5, 0, S_DONE, 0, 0, "t1_done_ignores");
        step(1); bus.I_match_vec = 4'b0000; step(1);

        // Hit on the last window cycle is accepted
        t = cyc; snap(t + 1, 0, S_RUN, 0, 0, "t2_arm");
        arm(1, 0, {2'd0, 2'd0, 2'd2, 2'd0}, {16'd0, 16'd0, 16'd5, 16'd0});
        t = cyc; bus.I_match_vec = 4'b0001;
        step(1); bus.I_match_vec = 4'b0000; step(4);
        bus.I_match_vec = 4'b0100;
        pulse_at(t + 6);
        snap(t + 6, 0, S_DONE, 0, 0, "t2_edge_hit");
        step(1); bus.I_match_vec = 4'b0000; step(1);

        // One cycle late: timeout, and the late strobe is not taken as stage 0
        t = cyc; snap(t + 1, 0, S_RUN, 0, 0, "t2b_arm");
        arm(1, 0, {2'd0, 2'd0, 2'd2, 2'd0}, {16'd0, 16'd0, 16'd5, 16'd0});
        t = cyc; bus.I_match_vec = 4'b0001;
        snap(t + 5, 0, S_RUN, 1, 0, "t2b_last_window");
        snap(t + 6, 0, S_RUN, 0, 1, "t2b_timeout");
        step(1); bus.I_match_vec = 4'b0000; step(5);
        bus.I_match_vec = 4'b0100;
        snap(t + 7, 0, S_RUN, 0, 1, "t2b_no_reeval");
        step(1); bus.I_match_vec = 4'b0000;

        // Abort keeps the timeout count
        t = cyc; bus.I_abort = 1'b1;
        snap(t + 1, 0, S_IDLE, 0, 1, "abort_holds_tmo");
        step(1); bus.I_abort = 1'b0; step(1);

        // Single-stage rearm: one pulse per hit, including back-to-back
        t = cyc; snap(t + 1, 0, S_RUN, 0, 0, "t3_arm_clears_tmo");
        arm(0, 1, 8'h01, 64'd0);
        t = cyc; bus.I_match_vec = 4'b0010;
        pulse_at(t + 1);
        snap(t + 1, 0, S_RUN, 0, 0, "t3_p1");
        step(1); bus.I_match_vec = 4'b0000; step(1);
        bus.I_match_vec = 4'b0010;
        pulse_at(t + 3); pulse_at(t + 4);
        step(2); bus.I_match_vec = 4'b0000;
        snap(t + 5, 0, S_RUN, 0, 0, "t3_stay_run");
        step(2);

        // Same matcher on consecutive stages advances one stage per hit
        t = cyc; snap(t + 1, 0, S_RUN, 0, 0, "rep_arm");
        arm(1, 0, 8'h00, 64'd0);
        t = cyc; bus.I_match_vec = 4'b0001;
        snap(t + 1, 0, S_RUN, 1, 0, "rep_one_stage");
        step(1); bus.I_match_vec = 4'b0000; step(1);
        bus.I_match_vec = 4'b0001;
        pulse_at(t + 3);
        snap(t + 3, 0, S_DONE, 0, 0, "rep_done");
        step(1); bus.I_match_vec = 4'b0000; step(1);

        // Shadow config and abort
        t = cyc; snap(t + 1, 0, S_RUN, 0, 0, "t4_arm");
        arm(2, 0, {2'd0, 2'd2, 2'd1, 2'd0}, 64'd0);
        bus.I_stage_sel = 8'hFF;
        t = cyc; bus.I_match_vec = 4'b0001;
        snap(t + 1, 0, S_RUN, 1, 0, "t4_stage1");
        step(1); bus.I_match_vec = 4'b0010;
        snap(t + 2, 0, S_RUN, 2, 0, "t4_stage2");
        step(1); bus.I_match_vec = 4'b1000;
        snap(t + 3, 0, S_RUN, 2, 0, "t4_shadow_kept");
        step(1); bus.I_match_vec = 4'b0100; bus.I_abort = 1'b1;
        snap(t + 4, 0, S_IDLE, 0, 0, "t4_abort");
        step(1); bus.I_abort = 1'b0; bus.I_match_vec = 4'b1111;
        snap(t + 5, 0, S_IDLE, 0, 0, "t4_idle_ignores");
        step(1); bus.I_match_vec = 4'b0000; bus.I_arm = 1'b1; bus.I_abort = 1'b1;
        snap(t + 6, 0, S_IDLE, 0, 0, "t4_arm_abort");
        step(1); bus.I_abort = 1'b0;
        snap(t + 7, 0, S_IDLE, 0, 0, "t4_level_no_edge");
        step(1); bus.I_arm = 1'b0; step(1);

        // Asynchronous reset in the middle of a clock period
        t = cyc; snap(t + 1, 0, S_RUN, 0, 0, "t5_arm");
        arm(1, 0, {2'd0, 2'd0, 2'd2, 2'd0}, {16'd0, 16'd0, 16'd1, 16'd0});
        t = cyc; bus.I_match_vec = 4'b0001;
        snap(t + 1, 0, S_RUN, 1, 0, "t5_s1");
        step(1); bus.I_match_vec = 4'b0000;
        snap(t + 2, 0, S_RUN, 0, 1, "t5_tmo");
        step(1); bus.I_match_vec = 4'b0001;
        snap(t + 3, 0, S_RUN, 1, 1, "t5_s1b");
        step(1); bus.I_match_vec = 4'b0000;
        snap(t + 4, 0, S_IDLE, 0, 0, "t5_async_reset");
        @(posedge fe_clk); #2; reset_i = 1'b1;
        step(1);
        reset_i = 1'b0;
        snap(t + 5, 0, S_IDLE, 0, 0, "t5_after_reset");
        step(1);

        // Timeout saturation on the 4-bit counter instance
        t = cyc;
        bus2.I_num_stages = 2'd1; bus2.I_rearm = 1'b0;
        bus2.I_stage_sel = {2'd0, 2'd0, 2'd3, 2'd0};
        bus2.I_stage_window = {16'd0, 16'd0, 16'd1, 16'd0};
        bus2.I_match_vec = 4'b0001; bus2.I_arm = 1'b1;
        snap(t + 1,  1, S_RUN, 0, 0,  "sat_arm");
        snap(t + 2,  1, S_RUN, 1, 0,  "sat_s1");
        snap(t + 3,  1, S_RUN, 0, 1,  "sat_tmo1");
        snap(t + 29, 1, S_RUN, 0, 14, "sat_tmo14");
        snap(t + 31, 1, S_RUN, 0, 15, "sat_reach");
        snap(t + 33, 1, S_RUN, 0, 15, "sat_hold16");
        snap(t + 35, 1, S_RUN, 0, 15, "sat_hold17");
        step(1); bus2.I_arm = 1'b0;
        step(36); bus2.I_match_vec = 4'b0000; step(1);

        // Unlimited window; stage 0 never times out
        t = cyc; snap(t + 1, 0, S_RUN, 0, 0, "t6_arm");
        arm(1, 0, {2'd0, 2'd0, 2'd2, 2'd0}, {16'd0, 16'd0, 16'd0, 16'd7});
        t = cyc; snap(t + 20, 0, S_RUN, 0, 0, "t6_stage0_no_timeout");
        step(20);
        t = cyc; bus.I_match_vec = 4'b0001;
        snap(t + 1, 0, S_RUN, 1, 0, "t6_s1");
        step(1); bus.I_match_vec = 4'b0000;
        snap(t + 999, 0, S_RUN, 1, 0, "t6_long_wait");
        step(999);
        bus.I_match_vec = 4'b0100;
        pulse_at(t + 1001);
        snap(t + 1001, 0, S_DONE, 0, 0, "t6_done");
        step(1); bus.I_match_vec = 4'b0000;
        step(3);
        stim_done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin : monitor
        snap_t       s;
        logic [1:0]  a_st, a_stg;
        logic [15:0] a_tmo;
        int          p;
        forever begin
            @(negedge fe_clk);
            if (stim_done) break;
            if (pulse_q.size() > 0 && pulse_q[0] < cyc) begin
                p = pulse_q.pop_front();
                total++; bad++;
                $display("FAIL pulse_missing: at cycle %0d O_match=0, required 1", p);
            end
            if (bus.O_match) begin
                total++;
                if (pulse_q.size() > 0 && pulse_q[0] == cyc)
                    p = pulse_q.pop_front();
                else begin
                    bad++;
                    $display("FAIL pulse_unexpected: at cycle %0d O_match=1, required 0", cyc);
                end
            end
            if (bus2.O_match) begin
                total++; bad++;
                $display("FAIL pulse_unexpected_sat: at cycle %0d O_match=1, required 0", cyc);
            end
            while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
                s = snap_q.pop_front();
                if (s.dut == 0) begin
                    a_st = bus.O_state; a_stg = bus.O_stage; a_tmo = bus.O_timeouts;
                end else begin
                    a_st = bus2.O_state; a_stg = bus2.O_stage; a_tmo = {12'd0, bus2.O_timeouts};
                end
                total++;
                if (a_st !== s.st || a_stg !== s.stg || a_tmo !== s.tmo) begin
                    bad++;
                    $display("FAIL %s: cycle %0d state/stage/timeouts got %0d/%0d/%0d, required %0d/%0d/%0d",
                             s.name, cyc, a_st, a_stg, a_tmo, s.st, s.stg, s.tmo);
                end
            end
        end
        while (pulse_q.size() > 0) begin
            p = pulse_q.pop_front();
            total++; bad++;
            $display("FAIL pulse_never_seen: cycle %0d O_match=0, required 1", p);
        end
        while (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            total++; bad++;
            $display("FAIL %s_unchecked: cycle %0d not reached, required state %0d", s.name, s.cyc, s.st);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Run-time bound
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, stimulus incomplete");
        $fatal(1, "time limit");
    end

endmodule
